// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF and MEM requests onto a byte-wide RAM, one byte per cycle.
// Define MEMCTRL_INST_BUF_EN to add a single-entry buffer for the last completed fetch.
`timescale 1ns/1ps
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_IF_RD  = 3'd1;
    localparam logic [2:0] S_MEM_RD = 3'd2;
    localparam logic [2:0] S_MEM_WR = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state;
    logic [2:0]        cnt;
    logic [2:0]        n_bytes;
    logic [2:0]        next_cnt;
    logic [2:0]        size_bytes;
    logic [1:0]        cap_idx;
    logic              is_if;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
    logic [31:0]       acc;
    logic [31:0]       rd_word;

`ifdef MEMCTRL_INST_BUF_EN
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_inst;
`endif

    assign next_cnt = cnt + 3'd1;
    // Read state runs cnt 0..N: the extra step captures the byte addressed in the last cycle.
    assign cap_idx  = cnt[1:0] - 2'd1;

    always_comb begin
        case (mem_size)
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    end

    always_comb begin
        rd_word = acc;
        rd_word[8*cap_idx +: 8] = ram_din;
    end

    assign if_done  = (state == S_DONE) && is_if && !if_flush;
    assign mem_done = (state == S_DONE) && !is_if;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            n_bytes   <= '0;
            is_if     <= 1'b0;
            base      <= '0;
            wdata     <= '0;
            acc       <= '0;
            if_inst   <= '0;
            mem_rdata <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_dout  <= '0;
`ifdef MEMCTRL_INST_BUF_EN
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_inst  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    acc <= '0;
                    if (mem_req) begin
                        state    <= mem_we ? S_MEM_WR : S_MEM_RD;
                        is_if    <= 1'b0;
                        base     <= mem_addr;
                        wdata    <= mem_wdata;
                        n_bytes  <= size_bytes;
                        ram_addr <= mem_addr;
                        ram_we   <= mem_we;
                        ram_dout <= mem_we ? mem_wdata[7:0] : 8'h00;
                    end else if (if_req && !if_flush) begin
                        is_if   <= 1'b1;
                        base    <= if_addr;
                        n_bytes <= 3'd4;
`ifdef MEMCTRL_INST_BUF_EN
                        if (buf_valid && (if_addr == buf_addr)) begin
                            state   <= S_DONE;
                            if_inst <= buf_inst;
                        end else begin
                            state    <= S_IF_RD;
                            ram_addr <= if_addr;
                        end
`else
                        state    <= S_IF_RD;
                        ram_addr <= if_addr;
`endif
                    end
                end
                S_IF_RD, S_MEM_RD: begin
                    if ((state == S_IF_RD) && if_flush) begin
                        state    <= S_IDLE;
                        cnt      <= '0;
                        ram_addr <= '0;
                    end else begin
                        if (cnt != 3'd0) acc <= rd_word;
                        if (cnt == n_bytes) begin
                            state    <= S_DONE;
                            ram_addr <= '0;
                            if (is_if) if_inst   <= rd_word;
                            else       mem_rdata <= rd_word;
                        end else begin
                            cnt <= next_cnt;
                            if (next_cnt != n_bytes)
                                ram_addr <= base + ADDR_W'(next_cnt);
                        end
                    end
                end
                S_MEM_WR: begin
                    if (next_cnt == n_bytes) begin
                        state    <= S_DONE;
                        ram_addr <= '0;
                        ram_we   <= 1'b0;
                        ram_dout <= '0;
                    end else begin
                        cnt      <= next_cnt;
                        ram_addr <= base + ADDR_W'(next_cnt);
                        ram_dout <= wdata[8*next_cnt[1:0] +: 8];
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    cnt   <= '0;
`ifdef MEMCTRL_INST_BUF_EN
                    if (is_if && !if_flush) begin
                        buf_valid <= 1'b1;
                        buf_addr  <= base;
                        buf_inst  <= if_inst;
                    end
`endif
                end
                default: begin
                    state    <= S_IDLE;
                    cnt      <= '0;
                    ram_addr <= '0;
                    ram_we   <= 1'b0;
                    ram_dout <= '0;
                end
            endcase
`ifdef MEMCTRL_INST_BUF_EN
            // Distance test is wrap-safe for buffered words straddling the top of memory.
            if ((state == S_MEM_WR) && ((ram_addr - buf_addr) < ADDR_W'(4)))
                buf_valid <= 1'b0;
`endif
        end
    end

endmodule
